// File: rtl/reg_wb_sched.sv
// Write-back scheduler: arbitrates ALU and load-unit write-back requests
// onto a single register-file write port, and keeps a per-register
// scoreboard that stalls issue on pending writes.
module reg_wb_sched #(
  parameter int unsigned NREG = 16,
  parameter int unsigned DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [3:0]      iss_rn,
  input  logic [3:0]      iss_rm,
  input  logic [3:0]      iss_rs,
  input  logic [3:0]      iss_rd,
  input  logic            iss_wb,
  output logic            iss_stall,
  input  logic            alu_req,
  input  logic [3:0]      alu_rd,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ack,
  input  logic            mem_req,
  input  logic [3:0]      mem_rd,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ack,
  output logic            w_en,
  output logic [3:0]      reg_d,
  output logic [DW-1:0]   w_data,
  output logic [NREG-1:0] busy
);

  // Identity of the requester granted most recently.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  gnt_e            last_q, last_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            w_en_q, w_en_d;
  logic [3:0]      reg_d_q, reg_d_d;
  logic [DW-1:0]   w_data_q, w_data_d;
  logic            alu_win, mem_win;
  logic            iss_set;

  // Scoreboard lookup; indices beyond NREG read as not busy.
  function automatic logic busy_bit(input logic [NREG-1:0] vec, input logic [3:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (idx == 4'(i)) r = vec[i];
    end
    return r;
  endfunction

  // Round-robin arbitration; acks and stall are forced low during reset.
  always_comb begin
    alu_win   = alu_req & (~mem_req | (last_q == GNT_MEM));
    mem_win   = mem_req & ~alu_win;
    alu_ack   = ~rst & alu_win;
    mem_ack   = ~rst & mem_win;
    iss_stall = ~rst & iss_valid &
                (busy_bit(busy_q, iss_rn) | busy_bit(busy_q, iss_rm) |
                 busy_bit(busy_q, iss_rs) | (iss_wb & busy_bit(busy_q, iss_rd)));
    iss_set   = ~rst & iss_valid & iss_wb & ~iss_stall;
  end

  // Next state: grant pointer, write port and scoreboard.
  always_comb begin
    last_d   = last_q;
    w_en_d   = alu_ack | mem_ack;
    reg_d_d  = reg_d_q;
    w_data_d = w_data_q;
    if (alu_ack) begin
      last_d   = GNT_ALU;
      reg_d_d  = alu_rd;
      w_data_d = alu_data;
    end else if (mem_ack) begin
      last_d   = GNT_MEM;
      reg_d_d  = mem_rd;
      w_data_d = mem_data;
    end
    // Clear first, then set, so an issue to the same register wins.
    busy_d = busy_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (alu_ack && alu_rd == 4'(i)) busy_d[i] = 1'b0;
      if (mem_ack && mem_rd == 4'(i)) busy_d[i] = 1'b0;
      if (iss_set && iss_rd == 4'(i)) busy_d[i] = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= GNT_MEM;
      busy_q   <= '0;
      w_en_q   <= 1'b0;
      reg_d_q  <= '0;
      w_data_q <= '0;
    end else begin
      last_q   <= last_d;
      busy_q   <= busy_d;
      w_en_q   <= w_en_d;
      reg_d_q  <= reg_d_d;
      w_data_q <= w_data_d;
    end
  end

  assign w_en   = w_en_q;
  assign reg_d  = reg_d_q;
  assign w_data = w_data_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed-vector and random-traffic bench for reg_wb_sched.
module tb_reg_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_wb;
  logic [3:0]  iss_rn, iss_rm, iss_rs, iss_rd;
  logic        iss_stall;
  logic        alu_req, alu_ack, mem_req, mem_ack;
  logic [3:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        w_en;
  logic [3:0]  reg_d;
  logic [31:0] w_data;
  logic [15:0] busy;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  reg_wb_sched #(.NREG(16), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rn(iss_rn), .iss_rm(iss_rm), .iss_rs(iss_rs),
    .iss_rd(iss_rd), .iss_wb(iss_wb), .iss_stall(iss_stall),
    .alu_req(alu_req), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ack(alu_ack),
    .mem_req(mem_req), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
    .w_en(w_en), .reg_d(reg_d), .w_data(w_data), .busy(busy)
  );

  typedef struct {
    logic        rst, iv, wb;
    logic [3:0]  rn, rm, rs, rd;
    logic        areq;
    logic [3:0]  ard;
    logic [31:0] adat;
    logic        mreq;
    logic [3:0]  mrd;
    logic [31:0] mdat;
    logic        e_stall, e_aack, e_mack, e_wen;
    logic [3:0]  e_regd;
    logic [31:0] e_wdata;
    logic [15:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic iv, input logic wb,
    input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs, input logic [3:0] rd,
    input logic areq, input logic [3:0] ard, input logic [31:0] adat,
    input logic mreq, input logic [3:0] mrd, input logic [31:0] mdat,
    input logic e_stall, input logic e_aack, input logic e_mack,
    input logic e_wen, input logic [3:0] e_regd, input logic [31:0] e_wdata,
    input logic [15:0] e_busy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.wb = wb; v.rn = rn; v.rm = rm; v.rs = rs; v.rd = rd;
    v.areq = areq; v.ard = ard; v.adat = adat;
    v.mreq = mreq; v.mrd = mrd; v.mdat = mdat;
    v.e_stall = e_stall; v.e_aack = e_aack; v.e_mack = e_mack;
    v.e_wen = e_wen; v.e_regd = e_regd; v.e_wdata = e_wdata; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic drive(input logic r, input logic iv, input logic wb,
                       input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs, input logic [3:0] rd,
                       input logic areq, input logic [3:0] ard, input logic [31:0] adat,
                       input logic mreq, input logic [3:0] mrd, input logic [31:0] mdat);
    rst = r; iss_valid = iv; iss_wb = wb;
    iss_rn = rn; iss_rm = rm; iss_rs = rs; iss_rd = rd;
    alu_req = areq; alu_rd = ard; alu_data = adat;
    mem_req = mreq; mem_rd = mrd; mem_data = mdat;
  endtask

  // Random-traffic reference model state.
  logic        m_last;   // 1 = MEM granted last
  logic [15:0] m_busy;
  logic        m_wen;
  logic [3:0]  m_regd;
  logic [31:0] m_wdata;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst iv wb rn rm rs rd | alu | mem | stall aack mack | wen regd wdata busy
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,32'h0,          0,0,32'h0,        0,0,0, 0,0,32'h0,          16'h0000));
    tbl.push_back(mk(1,0,0, 0,0,0,0, 1,7,32'h1111,       0,0,32'h0,        0,0,0, 0,0,32'h0,          16'h0000));
    tbl.push_back(mk(0,1,1, 0,0,0,5, 0,0,32'h0,          0,0,32'h0,        0,0,0, 0,0,32'h0,          16'h0020));
    tbl.push_back(mk(0,1,0, 5,0,0,0, 0,0,32'h0,          0,0,32'h0,        1,0,0, 0,0,32'h0,          16'h0020));
    tbl.push_back(mk(0,1,0, 5,0,0,0, 1,5,32'hDEADBEEF,   0,0,32'h0,        1,1,0, 1,5,32'hDEADBEEF,   16'h0000));
    tbl.push_back(mk(0,1,0, 5,0,0,0, 0,0,32'h0,          0,0,32'h0,        0,0,0, 0,5,32'hDEADBEEF,   16'h0000));
    tbl.push_back(mk(1,0,0, 0,0,0,0, 0,0,32'h0,          0,0,32'h0,        0,0,0, 0,0,32'h0,          16'h0000));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 1,1,32'hA0000001,   1,2,32'hB0000002, 0,1,0, 1,1,32'hA0000001,   16'h0000));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 1,3,32'hA0000003,   1,2,32'hB0000002, 0,0,1, 1,2,32'hB0000002,   16'h0000));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 1,3,32'hA0000003,   1,4,32'hB0000004, 0,1,0, 1,3,32'hA0000003,   16'h0000));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 1,5,32'hA0000005,   1,4,32'hB0000004, 0,0,1, 1,4,32'hB0000004,   16'h0000));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,32'h0,          0,0,32'h0,        0,0,0, 0,4,32'hB0000004,   16'h0000));
    tbl.push_back(mk(0,1,1, 0,0,0,3, 0,0,32'h0,          1,3,32'h33,       0,0,1, 1,3,32'h33,         16'h0008));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,32'h0,          1,3,32'h44,       0,0,1, 1,3,32'h44,         16'h0000));
    tbl.push_back(mk(0,1,1, 0,0,0,6, 0,0,32'h0,          0,0,32'h0,        0,0,0, 0,3,32'h44,         16'h0040));
    tbl.push_back(mk(0,1,1, 0,0,0,6, 0,0,32'h0,          0,0,32'h0,        1,0,0, 0,3,32'h44,         16'h0040));
    tbl.push_back(mk(0,1,0, 0,0,6,0, 0,0,32'h0,          0,0,32'h0,        1,0,0, 0,3,32'h44,         16'h0040));
    tbl.push_back(mk(0,1,1, 0,6,0,2, 0,0,32'h0,          0,0,32'h0,        1,0,0, 0,3,32'h44,         16'h0040));
    tbl.push_back(mk(1,1,0, 6,0,0,0, 1,9,32'h99,         0,0,32'h0,        0,0,0, 0,0,32'h0,          16'h0000));
    tbl.push_back(mk(0,0,0, 0,0,0,0, 0,0,32'h0,          0,0,32'h0,        0,0,0, 0,0,32'h0,          16'h0000));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].iv, tbl[i].wb, tbl[i].rn, tbl[i].rm, tbl[i].rs, tbl[i].rd,
            tbl[i].areq, tbl[i].ard, tbl[i].adat, tbl[i].mreq, tbl[i].mrd, tbl[i].mdat);
      #1;
      chk("iss_stall", i, 32'(iss_stall), 32'(tbl[i].e_stall));
      chk("alu_ack",   i, 32'(alu_ack),   32'(tbl[i].e_aack));
      chk("mem_ack",   i, 32'(mem_ack),   32'(tbl[i].e_mack));
      @(posedge clk);
      #1;
      chk("w_en",   i, 32'(w_en),  32'(tbl[i].e_wen));
      chk("reg_d",  i, 32'(reg_d), 32'(tbl[i].e_regd));
      chk("w_data", i, w_data,     tbl[i].e_wdata);
      chk("busy",   i, 32'(busy),  32'(tbl[i].e_busy));
    end

    // Random traffic against a reference model; starts from post-reset state.
    m_last = 1'b1; m_busy = '0; m_wen = 1'b0; m_regd = '0; m_wdata = '0;
    begin
      logic        ap, mp, iv, wb, ma, mm, mst;
      logic [3:0]  ard, mrd, rn, rm, rs, rd;
      logic [31:0] adat, mdat;
      int          a_wait, m_wait;
      ap = 0; mp = 0; ard = 0; mrd = 0; adat = 0; mdat = 0; a_wait = 0; m_wait = 0;
      for (int c = 0; c < 1000; c++) begin
        if (!ap && $urandom_range(0, 1) == 1) begin
          ap = 1; ard = 4'($urandom_range(0, 15)); adat = $urandom;
        end
        if (!mp && $urandom_range(0, 1) == 1) begin
          mp = 1; mrd = 4'($urandom_range(0, 15)); mdat = $urandom;
        end
        iv = 1'($urandom_range(0, 1)); wb = 1'($urandom_range(0, 1));
        rn = 4'($urandom_range(0, 15)); rm = 4'($urandom_range(0, 15));
        rs = 4'($urandom_range(0, 15)); rd = 4'($urandom_range(0, 15));
        @(negedge clk);
        drive(0, iv, wb, rn, rm, rs, rd, ap, ard, adat, mp, mrd, mdat);
        ma  = ap & (~mp | m_last);
        mm  = mp & ~ma;
        mst = iv & (m_busy[rn] | m_busy[rm] | m_busy[rs] | (wb & m_busy[rd]));
        #1;
        chk("rnd_ack_excl", c, 32'(alu_ack & mem_ack), 32'h0);
        chk("rnd_alu_ack",  c, 32'(alu_ack),   32'(ma));
        chk("rnd_mem_ack",  c, 32'(mem_ack),   32'(mm));
        chk("rnd_stall",    c, 32'(iss_stall), 32'(mst));
        m_wen = ma | mm;
        if (ma) begin m_last = 1'b0; m_regd = ard; m_wdata = adat; m_busy[ard] = 1'b0; end
        if (mm) begin m_last = 1'b1; m_regd = mrd; m_wdata = mdat; m_busy[mrd] = 1'b0; end
        if (iv && wb && !mst) m_busy[rd] = 1'b1;
        a_wait = ma ? 0 : (ap ? a_wait + 1 : 0);
        m_wait = mm ? 0 : (mp ? m_wait + 1 : 0);
        @(posedge clk);
        #1;
        if (a_wait > 1 || m_wait > 1)
          chk("rnd_starve", c, 32'(a_wait > 1 || m_wait > 1), 32'h0);
        chk("rnd_w_en",   c, 32'(w_en),  32'(m_wen));
        chk("rnd_reg_d",  c, 32'(reg_d), 32'(m_regd));
        chk("rnd_w_data", c, w_data,     m_wdata);
        chk("rnd_busy",   c, 32'(busy),  32'(m_busy));
        if (ma) ap = 0;
        if (mm) mp = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_wb_sched.md
REG_WB_SCHED -- requirements
Module: reg_wb_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NREG, 16, number of architectural registers. DW, 32, write-data width.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  reset; synchronous, active-high.
iss_valid  in  1  issue stage presents an instruction.
iss_rn, iss_rm, iss_rs  in  4  source register indices.
iss_rd  in  4  destination register index.
iss_wb  in  1  the instruction writes iss_rd.
iss_stall  out  1  hazard; the issue stage must hold.
alu_req  in  1  ALU write-back request.
alu_rd  in  4  ALU destination.
alu_data  in  DW  ALU result.
alu_ack  out  1  ALU request accepted this cycle.
mem_req  in  1  load-unit write-back request.
mem_rd  in  4  load destination.
mem_data  in  DW  load result.
mem_ack  out  1  load request accepted this cycle.
w_en  out  1  register-file write enable.
reg_d  out  4  register-file write index.
w_data  out  DW  register-file write data.
busy  out  NREG  scoreboard vector; bit i set = write to register i pending.

Function
REQ-003 Handshakes SHALL be req/ack: a requester holds req, rd and data stable until it samples ack high at a clock edge; ack is combinational from the current req inputs and the arbitration state.
REQ-004 At most one of alu_ack and mem_ack SHALL be high in any cycle.
REQ-005 With one req high, that requester SHALL be acked in the same cycle.
REQ-006 With both high, the grant SHALL be round-robin: the requester not granted most recently wins.
REQ-007 The last-grant pointer SHALL be a 1-bit register, reset to "MEM", so ALU wins the first conflict after reset. It updates only on a grant.
REQ-008 w_en, reg_d and w_data SHALL be registered with 1-cycle latency: an ack in cycle N drives w_en=1 with the winner's rd and data in cycle N+1. Otherwise w_en=0 and reg_d/w_data hold their last values.
REQ-009 Scoreboard set: on a clock edge where iss_valid=1, iss_wb=1 and iss_stall=0, busy[iss_rd] SHALL become 1.
REQ-010 Scoreboard clear: on a clock edge where a request is acked, busy[granted rd] SHALL become 0.
REQ-011 If a set and a clear target the same register at the same edge, the set SHALL win and the bit ends at 1.
REQ-012 iss_stall SHALL be combinational: iss_valid AND (busy[iss_rn] OR busy[iss_rm] OR busy[iss_rs] OR (iss_wb AND busy[iss_rd])).
REQ-013 iss_stall SHALL use only the registered busy vector, with no same-cycle bypass from the ack.
REQ-014 A write-back request whose rd has busy=0 SHALL still be granted and written, and the scoreboard SHALL be left unchanged.
REQ-015 A requester not acked SHALL see ack=0 and SHALL NOT lose its request; starvation beyond 1 cycle under continuous contention SHALL be impossible.

Reset
REQ-016 While rst=1 at a clock edge, the block SHALL set: busy=0, w_en=0, reg_d=0, w_data=0, last-grant pointer=MEM.
REQ-017 While rst=1, alu_ack=0, mem_ack=0 and iss_stall=0 SHALL hold, and no scoreboard set or clear occurs.
REQ-018 A reset asserted mid-operation SHALL discard any grant from that cycle; no w_en pulse follows it.

Verification
REQ-019 Reset then issue: rst for 2 cycles, then iss_valid=1, iss_wb=1, iss_rd=5 -> busy=0x0020 the next cycle; iss_stall=0 throughout.
REQ-020 RAW stall: with busy[5]=1, issue iss_rn=5 -> iss_stall=1. Then alu_req with alu_rd=5, alu_data=0xDEADBEEF -> alu_ack=1. Next cycle: w_en=1, reg_d=5, w_data=0xDEADBEEF, busy[5]=0, iss_stall=0.
REQ-021 Contention: alu_req and mem_req both held high for 4 cycles, first conflict after reset -> grant order ALU, MEM, ALU, MEM, and exactly one w_en per cycle with matching rd and data.
REQ-022 Set/clear collision: mem_ack for rd=3 in the same cycle as an unstalled issue with iss_rd=3 -> busy[3]=1 afterward.
REQ-023 Reset mid-grant: rst=1 in the cycle alu_req is high -> no ack, w_en=0 the next cycle, busy=0.
REQ-024 Random regression: 1000 cycles of random req/issue traffic, checked against a reference scoreboard model -> no mismatch, and no cycle with both acks high.
